// File: rtl/gty_prbs_pkg.sv
// -----------------------------------------------------------------------------
// gty_prbs_pkg
// Shared constants and helpers for the GTY TX fabric PRBS generator.
//   - prbssel encodings (passthrough, PRBS7/9/15/23/31; 6-15 reserved)
//   - polynomial lengths and tap positions for x^N + x^T + 1
//   - LFSR state width (31) and error counter width (16)
// Ports: none (package).
// -----------------------------------------------------------------------------
package gty_prbs_pkg;

   localparam int LFSR_W = 31;
   localparam int CNT_W  = 16;
   localparam int SEL_W  = 4;

   typedef logic [LFSR_W-1:0] lfsr_t;
   typedef logic [SEL_W-1:0]  prbs_sel_t;

   localparam prbs_sel_t SEL_PASS   = 4'd0;
   localparam prbs_sel_t SEL_PRBS7  = 4'd1;
   localparam prbs_sel_t SEL_PRBS9  = 4'd2;
   localparam prbs_sel_t SEL_PRBS15 = 4'd3;
   localparam prbs_sel_t SEL_PRBS23 = 4'd4;
   localparam prbs_sel_t SEL_PRBS31 = 4'd5;

   localparam int PRBS7_LEN  = 7;
   localparam int PRBS7_TAP  = 6;
   localparam int PRBS9_LEN  = 9;
   localparam int PRBS9_TAP  = 5;
   localparam int PRBS15_LEN = 15;
   localparam int PRBS15_TAP = 14;
   localparam int PRBS23_LEN = 23;
   localparam int PRBS23_TAP = 18;
   localparam int PRBS31_LEN = 31;
   localparam int PRBS31_TAP = 28;

   localparam lfsr_t LFSR_SEED = {LFSR_W{1'b1}};

   // True for the five implemented patterns; reserved codes act as passthrough.
   function automatic logic sel_is_prbs(input prbs_sel_t sel);
      return (sel >= SEL_PRBS7) && (sel <= SEL_PRBS31);
   endfunction

   // Feedback bit s[N-1] ^ s[T-1] for the selected polynomial. Only the low
   // N bits of the shared 31-bit register matter; upper bits are don't-care.
   function automatic logic prbs_fb(input lfsr_t s, input prbs_sel_t sel);
      case (sel)
         SEL_PRBS7:  return s[PRBS7_LEN-1]  ^ s[PRBS7_TAP-1];
         SEL_PRBS9:  return s[PRBS9_LEN-1]  ^ s[PRBS9_TAP-1];
         SEL_PRBS15: return s[PRBS15_LEN-1] ^ s[PRBS15_TAP-1];
         SEL_PRBS23: return s[PRBS23_LEN-1] ^ s[PRBS23_TAP-1];
         SEL_PRBS31: return s[PRBS31_LEN-1] ^ s[PRBS31_TAP-1];
         default:    return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/gty_prbs_lane.sv
// -----------------------------------------------------------------------------
// gty_prbs_lane
// One lane of the fabric PRBS generator: 31-bit Fibonacci LFSR unrolled to
// DATA_WIDTH bits per cycle, IDLE/RUN FSM, toggle-triggered single-bit error
// injection on bit 0, inhibit to zero, and an optional saturating counter of
// injected errors (enabled by `define GTY_TX_PRBS_ERR_CNT_EN).
//
// Ports:
//   gty_txusrclk2     in   TX user clock
//   gty_tx_reset_reg  in   async active-high reset
//   i_data            in   user data for passthrough
//   i_sel             in   pattern select (0 pass, 1..5 PRBS, others pass)
//   i_toggle          in   error request, every edge is one request
//   i_inhibit         in   force output word to zero
//   o_data            out  registered TX word, bit 0 transmitted first
//   o_err_count       out  injected-error count (GTY_TX_PRBS_ERR_CNT_EN only)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | passthrough; LFSR held at seed; pending error held
// ST_RUN   | LFSR advances DATA_WIDTH bits per cycle; output is PRBS word
// -----------------------------------------------------------------------------
module gty_prbs_lane
   import gty_prbs_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  gty_txusrclk2,
   input  logic                  gty_tx_reset_reg,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic [SEL_W-1:0]      i_sel,
   input  logic                  i_toggle,
   input  logic                  i_inhibit,
   output logic [DATA_WIDTH-1:0] o_data
`ifdef GTY_TX_PRBS_ERR_CNT_EN
   ,
   output logic [CNT_W-1:0]      o_err_count
`endif
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   logic                  r_state;
   prbs_sel_t             r_code;
   lfsr_t                 r_lfsr;
   logic                  r_toggle;
   logic                  r_pending;
   logic [DATA_WIDTH-1:0] r_data;

   logic                  w_edge;
   logic                  w_err;
   logic                  w_run;
   logic                  w_reseed;
   lfsr_t                 w_seed;
   lfsr_t                 w_lfsr_next;
   logic [DATA_WIDTH-1:0] w_word;
   logic [DATA_WIDTH-1:0] w_word_err;

   assign w_edge = i_toggle ^ r_toggle;
   // A request arriving this cycle lands in this cycle's word.
   assign w_err  = r_pending | w_edge;
   assign w_run  = sel_is_prbs(i_sel);
   // Entering RUN or switching pattern restarts from the seed in this word.
   assign w_reseed = (r_state == ST_IDLE) || (i_sel != r_code);
   assign w_seed   = w_reseed ? LFSR_SEED : r_lfsr;

   always_comb begin
      lfsr_t w_acc;
      logic  w_fb;
      w_acc  = w_seed;
      w_fb   = 1'b0;
      w_word = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         w_fb      = prbs_fb(w_acc, i_sel);
         w_word[i] = w_fb;
         w_acc     = {w_acc[LFSR_W-2:0], w_fb};
      end
      w_lfsr_next = w_acc;
   end

   always_comb begin
      w_word_err    = w_word;
      w_word_err[0] = w_word[0] ^ w_err;
   end

   always_ff @(posedge gty_txusrclk2 or posedge gty_tx_reset_reg) begin
      if (gty_tx_reset_reg) begin
         r_state   <= ST_IDLE;
         r_code    <= SEL_PASS;
         r_lfsr    <= LFSR_SEED;
         r_toggle  <= 1'b0;
         r_pending <= 1'b0;
         r_data    <= '0;
      end else begin
         r_toggle <= i_toggle;
         if (w_run) begin
            r_state   <= ST_RUN;
            r_code    <= i_sel;
            r_lfsr    <= w_lfsr_next;
            // The word consumes the request even when inhibited.
            r_pending <= 1'b0;
            r_data    <= i_inhibit ? '0 : w_word_err;
         end else begin
            r_state   <= ST_IDLE;
            r_code    <= SEL_PASS;
            r_lfsr    <= LFSR_SEED;
            r_pending <= w_err;
            r_data    <= i_inhibit ? '0 : i_data;
         end
      end
   end

   assign o_data = r_data;

`ifdef GTY_TX_PRBS_ERR_CNT_EN
   logic [CNT_W-1:0] r_err_cnt;

   always_ff @(posedge gty_txusrclk2 or posedge gty_tx_reset_reg) begin
      if (gty_tx_reset_reg) begin
         r_err_cnt <= '0;
      end else if (w_run && w_err && (r_err_cnt != {CNT_W{1'b1}})) begin
         r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign o_err_count = r_err_cnt;
`endif

endmodule

// File: rtl/gty_tx_prbs_gen.sv
// -----------------------------------------------------------------------------
// gty_tx_prbs_gen
// Multi-lane fabric PRBS generator between user TX data and GTY TXDATA.
// Each lane is an independent gty_prbs_lane; lane n uses slice n of every
// bus. Optional per-lane error counters: `define GTY_TX_PRBS_ERR_CNT_EN.
//
// Ports:
//   gty_txusrclk2     in   TX user clock
//   gty_tx_reset_reg  in   async active-high reset
//   tx_data_in        in   CHANNELS*DATA_WIDTH passthrough data
//   prbssel           in   CHANNELS*4 pattern select
//   forceerr_toggle   in   CHANNELS error-injection toggles
//   inhibit           in   CHANNELS force-to-zero
//   tx_data_out       out  CHANNELS*DATA_WIDTH registered TX data
//   err_count         out  CHANNELS*16 injected-error counts (macro only)
// -----------------------------------------------------------------------------
module gty_tx_prbs_gen
   import gty_prbs_pkg::*;
#(
   parameter int CHANNELS   = 1,
   parameter int DATA_WIDTH = 32
) (
   input  logic                           gty_txusrclk2,
   input  logic                           gty_tx_reset_reg,
   input  logic [CHANNELS*DATA_WIDTH-1:0] tx_data_in,
   input  logic [CHANNELS*SEL_W-1:0]      prbssel,
   input  logic [CHANNELS-1:0]            forceerr_toggle,
   input  logic [CHANNELS-1:0]            inhibit,
   output logic [CHANNELS*DATA_WIDTH-1:0] tx_data_out
`ifdef GTY_TX_PRBS_ERR_CNT_EN
   ,
   output logic [CHANNELS*CNT_W-1:0]      err_count
`endif
);

   if ((DATA_WIDTH < 8) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_width
      $error("gty_tx_prbs_gen: DATA_WIDTH must be >= 8 and a multiple of 8");
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      gty_prbs_lane #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_lane (
         .gty_txusrclk2    (gty_txusrclk2),
         .gty_tx_reset_reg (gty_tx_reset_reg),
         .i_data           (tx_data_in[g*DATA_WIDTH +: DATA_WIDTH]),
         .i_sel            (prbssel[g*SEL_W +: SEL_W]),
         .i_toggle         (forceerr_toggle[g]),
         .i_inhibit        (inhibit[g]),
         .o_data           (tx_data_out[g*DATA_WIDTH +: DATA_WIDTH])
`ifdef GTY_TX_PRBS_ERR_CNT_EN
         ,
         .o_err_count      (err_count[g*CNT_W +: CNT_W])
`endif
      );
   end

endmodule

// File: tb/tb_gty_tx_prbs_gen.sv
module tb_gty_tx_prbs_gen;

   localparam int CH   = 4;
   localparam int DW   = 32;
   localparam int MAXB = 131072;

   logic             clk = 1'b0;
   logic             rst;
   logic [CH*DW-1:0] din;
   logic [CH*4-1:0]  sel;
   logic [CH-1:0]    tog;
   logic [CH-1:0]    inh;
   logic [CH*DW-1:0] dout;
`ifdef GTY_TX_PRBS_ERR_CNT_EN
   logic [CH*16-1:0] errc;
`endif

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 0;

   always #5 clk = ~clk;

   gty_tx_prbs_gen #(
      .CHANNELS   (CH),
      .DATA_WIDTH (DW)
   ) dut (
      .gty_txusrclk2    (clk),
      .gty_tx_reset_reg (rst),
      .tx_data_in       (din),
      .prbssel          (sel),
      .forceerr_toggle  (tog),
      .inhibit          (inh),
      .tx_data_out      (dout)
`ifdef GTY_TX_PRBS_ERR_CNT_EN
      ,
      .err_count        (errc)
`endif
   );

   // ---------------- behavioural model ----------------
   // Each running lane keeps the full bit history since its last seed; a
   // PRBS-N bit is o[k] = o[k-N] ^ o[k-T], with o[negative] = 1 (the seed).
   bit          hist [CH][MAXB];
   int          hlen [CH];
   bit          m_run [CH];
   int          m_cur [CH];
   bit          m_pend [CH];
   bit          m_prev [CH];
   int          m_cnt [CH];
   logic [DW-1:0] exp_w [CH];

   function automatic int plen(input int code);
      case (code)
         1: return 7;  2: return 9;  3: return 15;  4: return 23;  default: return 31;
      endcase
   endfunction

   function automatic int ptap(input int code);
      case (code)
         1: return 6;  2: return 5;  3: return 14;  4: return 18;  default: return 28;
      endcase
   endfunction

   function automatic bit hbit(input int ln, input int k);
      if (k < 0) return 1'b1;
      return hist[ln][k];
   endfunction

   always @(posedge clk or posedge rst) begin : model
      int code, n, tp, k;
      bit b;
      logic [DW-1:0] w;
      if (rst) begin
         for (int l = 0; l < CH; l++) begin
            hlen[l] = 0; m_run[l] = 0; m_cur[l] = 0; m_pend[l] = 0;
            m_prev[l] = 0; m_cnt[l] = 0; exp_w[l] = '0;
         end
      end else begin
         for (int l = 0; l < CH; l++) begin
            code = int'(sel[l*4 +: 4]);
            if (tog[l] != m_prev[l]) m_pend[l] = 1;
            m_prev[l] = tog[l];
            if (code >= 1 && code <= 5) begin
               if (!m_run[l] || code != m_cur[l]) begin
                  hlen[l] = 0; m_run[l] = 1; m_cur[l] = code;
               end
               n = plen(code); tp = ptap(code);
               for (int i = 0; i < DW; i++) begin
                  k = hlen[l];
                  b = hbit(l, k - n) ^ hbit(l, k - tp);
                  hist[l][k] = b;
                  hlen[l] = k + 1;
                  w[i] = b;
               end
               if (m_pend[l]) begin
                  w[0] = ~w[0];
                  m_pend[l] = 0;
                  if (m_cnt[l] < 65535) m_cnt[l] = m_cnt[l] + 1;
               end
            end else begin
               m_run[l] = 0;
               w = din[l*DW +: DW];
            end
            exp_w[l] = inh[l] ? '0 : w;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         for (int l = 0; l < CH; l++) begin
            checks++;
            if (dout[l*DW +: DW] !== exp_w[l]) begin
               failures++;
               $display("FAIL lane%0d_data t=%0t got=%h want=%h", l, $time, dout[l*DW +: DW], exp_w[l]);
            end
`ifdef GTY_TX_PRBS_ERR_CNT_EN
            checks++;
            if (errc[l*16 +: 16] !== 16'(m_cnt[l])) begin
               failures++;
               $display("FAIL lane%0d_errcnt t=%0t got=%0d want=%0d", l, $time, errc[l*16 +: 16], m_cnt[l]);
            end
`endif
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic set_sel(input int ln, input int code);
      sel[ln*4 +: 4] = 4'(code);
   endtask

   function automatic logic [CH*DW-1:0] rnd_data();
      logic [CH*DW-1:0] d;
      for (int l = 0; l < CH; l++) d[l*DW +: DW] = $urandom;
      return d;
   endfunction

   // ---------------- stimulus ----------------
   initial begin : drive
      logic [DW-1:0] pw [8];
      int nbad;
      rst = 1'b1; din = '0; sel = '0; tog = '0; inh = '0;
      repeat (3) @(negedge clk);
      chk("reset_data", 128'(dout), 128'd0);
`ifdef GTY_TX_PRBS_ERR_CNT_EN
      chk("reset_errcnt", 128'(errc), 128'd0);
`endif
      rst = 1'b0;
      chk_en = 1'b1;

      // passthrough
      repeat (3) begin
         din = rnd_data();
         @(negedge clk);
      end

      // start all four patterns on different lanes
      set_sel(0, 1); set_sel(1, 2); set_sel(2, 3); set_sel(3, 4);
      din = rnd_data();
      @(negedge clk);
      chk("prbs7_first_bits", 128'(dout[6:0]), 128'h40);
      chk("prbs9_first_bits", 128'(dout[DW +: 10]), 128'h1E0);
      chk("prbs15_first_word", 128'(dout[2*DW +: DW]), 128'h3000_4000);
      chk("prbs23_first_word", 128'(dout[3*DW +: DW]), 128'h007C_0000);

      // PRBS7 repeats every 127 bits in the DUT stream
      pw[0] = dout[DW-1:0];
      for (int j = 1; j < 8; j++) begin
         @(negedge clk);
         pw[j] = dout[DW-1:0];
      end
      nbad = 0;
      for (int k = 127; k < 8*DW; k++)
         if (pw[k/DW][k%DW] != pw[(k-127)/DW][(k-127)%DW]) nbad++;
      chk("prbs7_period127", 128'(nbad), 128'd0);

      // single injection in RUN
      tog[0] = ~tog[0];
      @(negedge clk);
`ifdef GTY_TX_PRBS_ERR_CNT_EN
      chk("errcnt_after_one", 128'(errc[15:0]), 128'd1);
`endif
      repeat (2) @(negedge clk);

      // two requests in IDLE merge, passthrough untouched, first RUN word hit
      set_sel(0, 0);
      din = rnd_data();
      @(negedge clk);
      tog[0] = ~tog[0];
      @(negedge clk);
      tog[0] = ~tog[0];
      @(negedge clk);
      set_sel(0, 1);
      @(negedge clk);
      chk("idle_err_first_run_word", 128'(dout[6:0]), 128'h41);
`ifdef GTY_TX_PRBS_ERR_CNT_EN
      chk("errcnt_merged", 128'(errc[15:0]), 128'd2);
`endif

      // inhibit five cycles; release must be time-aligned
      inh = '1;
      repeat (5) begin
         @(negedge clk);
         chk("inhibit_zero", 128'(dout), 128'd0);
      end
      inh = '0;
      repeat (2) @(negedge clk);

      // 5 -> 3 -> 5 restarts from the seed
      set_sel(2, 5);
      @(negedge clk);
      chk("prbs31_first_word", 128'(dout[2*DW +: DW]), 128'h7000_0000);
      repeat (4) @(negedge clk);
      set_sel(2, 3);
      @(negedge clk);
      chk("prbs15_reseed", 128'(dout[2*DW +: DW]), 128'h3000_4000);
      repeat (2) @(negedge clk);
      set_sel(2, 5);
      @(negedge clk);
      chk("prbs31_reseed", 128'(dout[2*DW +: DW]), 128'h7000_0000);
      repeat (3) @(negedge clk);

      // asynchronous reset mid-RUN
      #2 rst = 1'b1;
      #1 chk("async_reset_data", 128'(dout), 128'd0);
`ifdef GTY_TX_PRBS_ERR_CNT_EN
      chk("async_reset_errcnt", 128'(errc), 128'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // randomized phase
      for (int c = 0; c < 1500; c++) begin
         din = rnd_data();
         for (int l = 0; l < CH; l++) begin
            if ($urandom_range(0, 19) == 0) begin
               int r;
               r = $urandom_range(0, 9);
               set_sel(l, (r <= 5) ? r : $urandom_range(6, 15));
            end
            if ($urandom_range(0, 7) == 0) tog[l] = ~tog[l];
            if ($urandom_range(0, 15) == 0) inh[l] = ~inh[l];
         end
         @(negedge clk);
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gty_tx_prbs_gen.md
# gty_tx_prbs_gen

Multi-lane fabric PRBS pattern generator for the GTY TX datapath, clocked by the transmitter user clock. It replaces transceiver-internal PRBS with a fabric generator that offers per-lane pattern selection, parallel word generation at any data width, toggle-triggered single-bit error injection and per-lane inhibit. It sits between user TX data and the GTY TXDATA port. Its controls come from the already-synchronised TX control registers of the XFCP GTY management module.

## Interface
- CHANNELS, 1: number of independent lanes.
- DATA_WIDTH, 32: bits per lane per cycle; must be ≥ 8 and a multiple of 8.
- gty_txusrclk2 in 1: TX user clock; the only clock in the block.
- gty_tx_reset_reg in 1: reset, asynchronous, active-high; clock gty_txusrclk2.
- tx_data_in in CHANNELS*DATA_WIDTH: user data for passthrough; lane n occupies [n*DATA_WIDTH +: DATA_WIDTH].
- prbssel in CHANNELS*4: per-lane pattern select, already synchronous to gty_txusrclk2.
- forceerr_toggle in CHANNELS: per-lane error-injection request; every edge is one request.
- inhibit in CHANNELS: per-lane force of the output to zero.
- tx_data_out out CHANNELS*DATA_WIDTH: registered data to GTY TXDATA.
- err_count out CHANNELS*16: injected-error count per lane. Present only with GTY_TX_PRBS_ERR_CNT_EN.

## Operation
- prbssel encoding:
  - 0: passthrough.
  - 1: PRBS7, x^7+x^6+1.
  - 2: PRBS9, x^9+x^5+1.
  - 3: PRBS15, x^15+x^14+1.
  - 4: PRBS23, x^23+x^18+1.
  - 5: PRBS31, x^31+x^28+1.
  - 6–15: reserved; treated as passthrough.
- Each lane has a 31-bit Fibonacci LFSR; only the low N bits are used for PRBS-N. New bit = s[N-1]^s[tap-1]; the register shifts left with the new bit entering s[0]. The output bit equals the new bit. The output is not inverted.
- Each cycle a lane produces DATA_WIDTH consecutive bits. Bit 0 is the earliest bit and is transmitted first.
- Lane FSM has two states:
  - IDLE (passthrough): LFSR held at all-ones.
  - RUN: LFSR advances DATA_WIDTH bits per cycle.
- FSM transitions:
  - IDLE→RUN: prbssel becomes a valid PRBS code.
  - RUN→IDLE: prbssel becomes passthrough or reserved.
  - RUN→RUN with a different code: LFSR reseeds to all-ones; the first word after the change starts the new sequence from the seed.
- Error injection:
  - Edge detect on forceerr_toggle: registered copy XOR current value.
  - A detected edge sets pending_err.
  - The next word emitted in RUN has bit 0 inverted, and pending_err then clears.
  - In IDLE, pending_err is held until RUN is entered.
- Priority within a cycle: inhibit over data. A word with an injected error that is inhibited still consumes pending_err and still counts.
- Two requests before consumption merge into one injection.
- The LFSR keeps advancing while inhibit is high, so the sequence stays time-aligned.

## Timing
- Reset values:
  - tx_data_out = 0.
  - err_count = 0.
  - LFSR = all-ones.
  - FSM = IDLE.
  - pending_err = 0.
  - Toggle history = 0.
- Latency: one gty_txusrclk2 cycle from tx_data_in, prbssel, inhibit or forceerr_toggle to tx_data_out. Passthrough data is delayed by exactly 1 cycle.
- Selection change at cycle t: the word at t+1 is the first seeded word of the new pattern.
- Toggle edge at t: the error appears in the word at t+1. If prbssel changes in the same cycle t, the error lands in the first word of the new pattern.
- Reset asserted mid-operation: all state clears immediately. After deassertion the first word is seeded, or passthrough if prbssel is passthrough or reserved.
- err_count saturates at 16'hFFFF and does not wrap.
- No backpressure; one word every cycle.

## Configuration
- GTY_TX_PRBS_ERR_CNT_EN defined: per-lane 16-bit saturating counter of injected errors, driven on err_count.
- Not defined: err_count port and counters are absent. Injection behaviour is unchanged.

## Structure
- Package gty_prbs_pkg holds:
  - PRBS select encoding constants.
  - Polynomial lengths and tap positions.
  - LFSR state width (31).
  - Counter width (16).
- Sub-module gty_prbs_lane implements one lane: LFSR with parallel next-state logic, FSM, pending_err and optional counter. The top generates CHANNELS instances.

## Test plan
- Reset, then prbssel=1 on lane 0 with DATA_WIDTH=32:
  - First word bits 0–5 = 0 and bit 6 = 1.
  - Stream matches a bit-serial model.
  - Stream repeats every 127 bits.
- prbssel=5 for 2^31 bits via model comparison, or a sampled window → no mismatch against the model; sequence restarts from the seed after a 5→3→5 change.
- Single toggle on forceerr_toggle in RUN:
  - Exactly one word, at t+1, differs from the model, in bit 0 only.
  - err_count = 1.
  - Two toggles in one cycle window before consumption → one error.
- Toggle while prbssel=0 → no corruption of passthrough; the first RUN word has bit 0 inverted.
- inhibit=1 for 5 cycles in RUN → output 0. On release, the output matches the model at the time-aligned position, not a resumed one.
- Reset asserted mid-RUN with CHANNELS=4:
  - All outputs are 0 within the same cycle.
  - err_count = 0.
  - After release, lanes with different prbssel run independently.
